seven_seg_scan_reader: RTL and testbench
========================================

# seven_seg_scan_reader

Receive-side companion to the binary-to-seven-segment decoder: it watches a time-multiplexed 4-digit seven-segment bus, filters glitches, and decodes each active-low pattern back to a 4-bit digit value. It assembles complete 4-digit frames and presents them on a val/rdy stream. It sits in test and debug logic beside the display driver, so display output can be checked against processor state in simulation and on the board.

## Interface
- STABLE_CYCLES, default 4: consecutive cycles a {seg, dsel} pair must match before it is captured. Legal range 1..255.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- seg  input  7  active-low segment pattern; bit 0 = a (top), then b, c, d, e, f, with bit 6 = g (middle).
- dsel  input  4  one-hot, active-high digit select; bit i = digit i (digit 0 = least significant).
- out_val  output  1  a frame is valid on out_digits/out_err.
- out_rdy  input  1  the consumer accepts the frame.
- out_digits  output  16  nibble i = decoded value of digit i.
- out_err  output  4  bit i = 1 means digit i held an undecodable pattern.
- drop_count  output  8  saturating count of frames dropped because of backpressure.

## Operation
- **Input register:** seg_q and dsel_q load {seg, dsel} every cycle.
  - Reset values: seg_q = 7'h7F, dsel_q = 0.
- **Stability counter:** `eq = ({seg, dsel} == {seg_q, dsel_q})`.
  - cnt <= eq ? min(cnt+1, STABLE_CYCLES) : 0.
- **Capture:** fires when eq is true, cnt == STABLE_CYCLES-1, and dsel_q is one-hot.
  - Exactly one capture per stable run.
  - dsel_q of zero or multi-hot is never captured.
- **Decode of seg_q:**
  - 0 = 40, 1 = 79, 2 = 24, 3 = 30, 4 = 19, 5 = 12, 6 = 02, 7 = 78, 8 = 00, 9 = 18 (hex).
  - Pattern 00 always decodes to 8; the encoder's 8 and A–F all share this pattern.
  - Any other pattern gives nibble F with err = 1.
- **Staging:** a capture writes stage_digit[i], stage_err[i] and sets seen[i].
  - Recapturing a slot overwrites it; the latest capture wins.
- **Frame complete:** seen | capture_mask == 4'hF at the capturing edge.
- **FSM states:** COLLECT, PRESENT. Collection runs in both states.
  - COLLECT, frame complete: load out_digits/out_err from staging (including the same-edge capture), clear seen, go to PRESENT.
  - PRESENT, out_rdy and no frame complete: go to COLLECT. Output data registers hold their value.
  - PRESENT, out_rdy and frame complete: load the new frame, stay in PRESENT. No drop.
  - PRESENT, frame complete and no out_rdy: keep the old frame, clear seen, increment drop_count (saturates at 255).
- **Output rules:** out_val = (state == PRESENT). out_digits and out_err are stable while out_val && !out_rdy.
- **Reset:** applies on any edge with rst = 1, including mid-frame or mid-handshake.
  - state = COLLECT, seen = 0, cnt = 0, stage and outputs = 0, drop_count = 0.
  - out_val = 0 in the cycle after the reset edge.

## Timing
- Counting from the first cycle t in which a new {seg, dsel} is stable at the inputs (and differs from what was there in cycle t-1), the capture edge is the end of cycle t+STABLE_CYCLES.
- When that capture completes the frame, out_val = 1 from cycle t+STABLE_CYCLES+1.
- Minimum dwell for a digit to register is STABLE_CYCLES+1 cycles.
- A handshake completes on an edge where out_val && out_rdy; out_val falls in the next cycle unless a new frame loaded on that same edge.
- No combinational path from inputs to outputs; out_rdy affects state only.

## Test plan
- **Basic frame:** after reset, STABLE_CYCLES = 4, hold out_rdy = 1, scan digits 0..3 with patterns 30, 24, 79, 40, each for 5 cycles.
  - Expect out_val to pulse for 1 cycle, 5 cycles after digit 3 starts, with out_digits = 16'h0123 and out_err = 0.
- **Glitch rejection:** on digit 2, show pattern 79 for 3 cycles, then 1 cycle of 7F, then 79 again for 5 cycles.
  - Expect exactly one capture, after the second run.
  - Expect no capture of 7F on the 1-cycle glitch.
- **Invalid and alias patterns:** digit 1 = 7F, digit 3 = 00, others valid.
  - Expect out_err = 4'b0010, nibble 1 = F, nibble 3 = 8.
- **Bad select:** drive dsel = 0000 and then 0011 for 20 cycles.
  - Expect seen unchanged and no out_val.
- **Backpressure:** hold out_rdy = 0 across two full scans (1234, then 5678).
  - Expect out_digits to stay at 16'h1234 and drop_count = 1.
  - Then assert out_rdy: expect one accept, then out_val = 0.
  - Repeat with out_rdy asserted exactly on the second frame's completion edge: expect 5678 loaded, out_val still 1, drop_count unchanged.
- **Reset mid-operation:** assert rst for 1 cycle after 2 digits are captured and while out_val = 1.
  - Expect out_val = 0, out_digits = 0, and drop_count = 0.
  - A new frame then requires all four digits again.

Source files
------------

// File: rtl/seven_seg_scan_reader.sv
// rtl/seven_seg_scan_reader.sv - glitch-filtered 4-digit seven-segment scan decoder with framed val/rdy output
module seven_seg_scan_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  dsel,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [15:0] out_digits,
    output logic [3:0]  out_err,
    output logic [7:0]  drop_count
);

    localparam logic [7:0] STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [6:0]  seg_q;
    logic [3:0]  dsel_q;
    logic [7:0]  cnt;
    logic        eq;
    logic        onehot;
    logic        capture;
    logic        complete;
    logic [3:0]  dec_val;
    logic        dec_err;

    logic [15:0] stage_digit;
    logic [3:0]  stage_err;
    logic [3:0]  seen;
    logic [15:0] merged_digit;
    logic [3:0]  merged_err;

    logic        load;
    logic        drop;

    assign eq       = ({seg, dsel} == {seg_q, dsel_q});
    assign onehot   = (dsel_q != 4'd0) && ((dsel_q & (dsel_q - 4'd1)) == 4'd0);
    assign capture  = eq && (cnt == STABLE_LAST) && onehot;
    assign complete = capture && ((seen | dsel_q) == 4'hF);
    assign out_val  = (state == PRESENT);

    // Input register and stability counter; the counter saturates so a run captures once
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q  <= 7'h7F;
            dsel_q <= 4'd0;
            cnt    <= 8'd0;
        end else begin
            seg_q  <= seg;
            dsel_q <= dsel;
            if (eq) begin
                cnt <= (cnt == STABLE_MAX) ? cnt : cnt + 8'd1;
            end else begin
                cnt <= 8'd0;
            end
        end
    end

    // Active-low pattern back to digit value; 00 is reported as 8 since 8 and A-F share it
    always_comb begin
        dec_val = 4'hF;
        dec_err = 1'b0;
        case (seg_q)
            7'h40:   dec_val = 4'd0;
            7'h79:   dec_val = 4'd1;
            7'h24:   dec_val = 4'd2;
            7'h30:   dec_val = 4'd3;
            7'h19:   dec_val = 4'd4;
            7'h12:   dec_val = 4'd5;
            7'h02:   dec_val = 4'd6;
            7'h78:   dec_val = 4'd7;
            7'h00:   dec_val = 4'd8;
            7'h18:   dec_val = 4'd9;
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Staging contents as they will be after this edge, so a completing capture is included
    always_comb begin
        merged_digit = stage_digit;
        merged_err   = stage_err;
        for (int i = 0; i < 4; i++) begin
            if (capture && dsel_q[i]) begin
                merged_digit[i*4 +: 4] = dec_val;
                merged_err[i]          = dec_err;
            end
        end
    end

    // Staging slots; seen restarts whenever a frame is completed, whether presented or dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_digit <= 16'd0;
            stage_err   <= 4'd0;
            seen        <= 4'd0;
        end else if (capture) begin
            stage_digit <= merged_digit;
            stage_err   <= merged_err;
            seen        <= complete ? 4'd0 : (seen | dsel_q);
        end
    end

    // Handshake state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= COLLECT;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus load/drop decisions for completed frames
    always_comb begin
        next_state = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            COLLECT: begin
                if (complete) begin
                    load       = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (complete) begin
                    if (out_rdy) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (out_rdy) begin
                    next_state = COLLECT;
                end
            end
            default: next_state = COLLECT;
        endcase
    end

    // Output frame registers and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out_digits <= 16'd0;
            out_err    <= 4'd0;
            drop_count <= 8'd0;
        end else begin
            if (load) begin
                out_digits <= merged_digit;
                out_err    <= merged_err;
            end
            if (drop && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_reader.sv
// tb/tb_seven_seg_scan_reader.sv - self-checking bench for seven_seg_scan_reader
module tb_seven_seg_scan_reader;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  dsel;
    logic        out_val;
    logic        out_rdy;
    logic [15:0] out_digits;
    logic [3:0]  out_err;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0] pats [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18};

    // reference model state
    logic [10:0] m_last;
    int          m_run;
    int          m_seen;
    logic [3:0]  m_sd [4];
    logic [3:0]  m_se;
    logic        m_pres;
    logic [15:0] m_od;
    logic [3:0]  m_oe;
    int          m_drop;

    seven_seg_scan_reader #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dsel       (dsel),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .out_digits (out_digits),
        .out_err    (out_err),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // advance one clock, updating the reference model from the inputs applied in this cycle
    task automatic tick();
        logic [10:0] cur;
        int idx;
        logic [3:0] v;
        logic e;
        cur = {seg, dsel};
        if (rst) begin
            m_last = {7'h7F, 4'h0};
            m_run  = 1;
            m_seen = 0;
            for (int k = 0; k < 4; k++) m_sd[k] = 4'h0;
            m_se   = 4'h0;
            m_pres = 1'b0;
            m_od   = 16'h0;
            m_oe   = 4'h0;
            m_drop = 0;
        end else begin
            if (cur == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_run = 1;
            end
            m_last = cur;
            if (m_run == S + 1 && $countones(dsel) == 1) begin
                idx = 0;
                for (int k = 0; k < 4; k++) if (dsel[k]) idx = k;
                v = 4'hF;
                e = 1'b1;
                for (int k = 0; k < 10; k++) begin
                    if (seg == pats[k]) begin
                        v = 4'(k);
                        e = 1'b0;
                    end
                end
                m_sd[idx] = v;
                m_se[idx] = e;
                if ((m_seen | (1 << idx)) == 15) begin
                    if (!m_pres || out_rdy) begin
                        m_pres = 1'b1;
                        m_od   = {m_sd[3], m_sd[2], m_sd[1], m_sd[0]};
                        m_oe   = m_se;
                    end else if (m_drop < 255) begin
                        m_drop++;
                    end
                    m_seen = 0;
                end else begin
                    m_seen = m_seen | (1 << idx);
                    if (m_pres && out_rdy) m_pres = 1'b0;
                end
            end else if (m_pres && out_rdy) begin
                m_pres = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [6:0] p, logic [3:0] ds, int n);
        seg  = p;
        dsel = ds;
        repeat (n) tick();
    endtask

    task automatic show(int d, logic [6:0] p, int n);
        drive(p, 4'(1 << d), n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        out_rdy = 1'b1;
        seg = 7'h7F;
        dsel = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if (out_val !== 1'b0) begin miscompares++; $display("FAIL reset_val got %b exp 0", out_val); end
        vectors++;
        if (out_digits !== 16'h0) begin miscompares++; $display("FAIL reset_digits got %h exp 0000", out_digits); end
        vectors++;
        if (out_err !== 4'h0) begin miscompares++; $display("FAIL reset_err got %b exp 0000", out_err); end
        vectors++;
        if (drop_count !== 8'h0) begin miscompares++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
    endtask

    task automatic test_basic_frame();
        out_rdy = 1'b1;
        drive(7'h7F, 4'h0, 2);
        show(0, 7'h30, 5);
        show(1, 7'h24, 5);
        show(2, 7'h79, 5);
        for (int c = 1; c <= 5; c++) begin
            show(3, 7'h40, 1);
            vectors++;
            if (out_val !== (c == 5)) begin miscompares++; $display("FAIL basic_val_c%0d got %b exp %b", c, out_val, (c == 5)); end
        end
        vectors++;
        if (out_digits !== 16'h0123) begin miscompares++; $display("FAIL basic_digits got %h exp 0123", out_digits); end
        vectors++;
        if (out_err !== 4'h0) begin miscompares++; $display("FAIL basic_err got %b exp 0000", out_err); end
        drive(7'h7F, 4'h0, 1);
        vectors++;
        if (out_val !== 1'b0) begin miscompares++; $display("FAIL basic_pulse_end got %b exp 0", out_val); end
    endtask

    task automatic test_glitch();
        out_rdy = 1'b1;
        show(0, 7'h40, 5);
        show(1, 7'h79, 5);
        show(3, 7'h30, 5);
        show(2, 7'h79, 3);
        show(2, 7'h7F, 1);
        vectors++;
        if (out_val !== 1'b0) begin miscompares++; $display("FAIL glitch_early got %b exp 0", out_val); end
        for (int c = 1; c <= 5; c++) begin
            show(2, 7'h79, 1);
            vectors++;
            if (out_val !== (c == 5)) begin miscompares++; $display("FAIL glitch_val_c%0d got %b exp %b", c, out_val, (c == 5)); end
        end
        vectors++;
        if (out_digits !== 16'h3110 || out_err !== 4'h0) begin
            miscompares++; $display("FAIL glitch_frame got %h/%b exp 3110/0000", out_digits, out_err);
        end
        drive(7'h7F, 4'h0, 2);
    endtask

    task automatic test_invalid_alias();
        out_rdy = 1'b1;
        show(0, 7'h40, 5);
        show(1, 7'h7F, 5);
        show(2, 7'h79, 5);
        show(3, 7'h00, 5);
        vectors++;
        if (out_val !== 1'b1) begin miscompares++; $display("FAIL alias_val got %b exp 1", out_val); end
        vectors++;
        if (out_digits !== 16'h81F0) begin miscompares++; $display("FAIL alias_digits got %h exp 81f0", out_digits); end
        vectors++;
        if (out_err !== 4'b0010) begin miscompares++; $display("FAIL alias_err got %b exp 0010", out_err); end
        drive(7'h7F, 4'h0, 2);
    endtask

    task automatic test_bad_select();
        int seen_val;
        out_rdy = 1'b1;
        seen_val = 0;
        show(0, 7'h19, 5);
        show(1, 7'h30, 5);
        show(2, 7'h24, 5);
        for (int c = 0; c < 40; c++) begin
            drive(7'h12, (c < 20) ? 4'b0000 : 4'b0011, 1);
            if (out_val !== 1'b0) seen_val++;
        end
        vectors++;
        if (seen_val != 0) begin miscompares++; $display("FAIL badsel_no_val got %0d cycles exp 0", seen_val); end
        show(3, 7'h79, 5);
        vectors++;
        if (out_val !== 1'b1 || out_digits !== 16'h1234) begin
            miscompares++; $display("FAIL badsel_frame got %b/%h exp 1/1234", out_val, out_digits);
        end
        drive(7'h7F, 4'h0, 2);
    endtask

    task automatic scan_1234();
        show(0, 7'h19, 5);
        show(1, 7'h30, 5);
        show(2, 7'h24, 5);
        show(3, 7'h79, 5);
    endtask

    task automatic test_back_to_back();
        out_rdy = 1'b0;
        scan_1234();
        show(0, 7'h00, 5);
        show(1, 7'h78, 5);
        show(2, 7'h02, 5);
        show(3, 7'h12, 5);
        vectors++;
        if (out_val !== 1'b1 || out_digits !== 16'h1234) begin
            miscompares++; $display("FAIL bp_hold got %b/%h exp 1/1234", out_val, out_digits);
        end
        vectors++;
        if (drop_count !== 8'd1) begin miscompares++; $display("FAIL bp_drop got %0d exp 1", drop_count); end
        out_rdy = 1'b1;
        drive(7'h7F, 4'h0, 1);
        vectors++;
        if (out_val !== 1'b0) begin miscompares++; $display("FAIL bp_accept got %b exp 0", out_val); end

        out_rdy = 1'b0;
        scan_1234();
        show(0, 7'h00, 5);
        show(1, 7'h78, 5);
        show(2, 7'h02, 5);
        show(3, 7'h12, 4);
        out_rdy = 1'b1;
        show(3, 7'h12, 1);
        vectors++;
        if (out_val !== 1'b1 || out_digits !== 16'h5678) begin
            miscompares++; $display("FAIL bp_sameedge got %b/%h exp 1/5678", out_val, out_digits);
        end
        vectors++;
        if (drop_count !== 8'd1) begin miscompares++; $display("FAIL bp_sameedge_drop got %0d exp 1", drop_count); end
        drive(7'h7F, 4'h0, 1);
        vectors++;
        if (out_val !== 1'b0) begin miscompares++; $display("FAIL bp_sameedge_end got %b exp 0", out_val); end
    endtask

    task automatic test_reset_mid();
        out_rdy = 1'b0;
        scan_1234();
        show(0, 7'h40, 5);
        show(1, 7'h40, 5);
        vectors++;
        if (out_val !== 1'b1 || drop_count !== 8'd1) begin
            miscompares++; $display("FAIL rmid_pre got %b/%0d exp 1/1", out_val, drop_count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (out_val !== 1'b0 || out_digits !== 16'h0 || drop_count !== 8'd0) begin
            miscompares++; $display("FAIL rmid_after got %b/%h/%0d exp 0/0000/0", out_val, out_digits, drop_count);
        end
        out_rdy = 1'b1;
        show(2, 7'h40, 5);
        show(3, 7'h40, 5);
        vectors++;
        if (out_val !== 1'b0) begin miscompares++; $display("FAIL rmid_partial got %b exp 0", out_val); end
        show(0, 7'h79, 5);
        show(1, 7'h79, 5);
        vectors++;
        if (out_val !== 1'b1 || out_digits !== 16'h0011) begin
            miscompares++; $display("FAIL rmid_refill got %b/%h exp 1/0011", out_val, out_digits);
        end
        drive(7'h7F, 4'h0, 2);
    endtask

    task automatic test_random();
        int dur;
        logic [6:0] p;
        logic [3:0] ds;
        for (int r = 0; r < 180; r++) begin
            dur = $urandom_range(1, 7);
            p   = ($urandom_range(0, 4) == 0) ? 7'($urandom) : pats[$urandom_range(0, 9)];
            ds  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
            for (int c = 0; c < dur; c++) begin
                seg     = p;
                dsel    = ds;
                out_rdy = ($urandom_range(0, 2) != 0);
                rst     = ($urandom_range(0, 299) == 0);
                tick();
                vectors++;
                if (out_val !== m_pres || out_digits !== m_od || out_err !== m_oe || drop_count !== 8'(m_drop)) begin
                    miscompares++;
                    $display("FAIL rand_r%0d got val=%b dig=%h err=%b drop=%0d exp val=%b dig=%h err=%b drop=%0d",
                             r, out_val, out_digits, out_err, drop_count, m_pres, m_od, m_oe, m_drop);
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        out_rdy = 1'b1;
        seg = 7'h7F;
        dsel = 4'h0;
        test_reset();
        test_basic_frame();
        test_glitch();
        test_invalid_alias();
        test_bad_select();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
